// File: rtl/bcd_countdown_timer_if.sv
// Control/data bundle of the BCD countdown timer; the master drives the
// controls and loads the count, the slave (the timer) drives the status back.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   digits_in;
  logic                  start;
  logic                  stop;
  logic                  tick;
  logic [4*DIGITS-1:0]   digits_out;
  logic                  running;
  logic                  zero;
  logic                  done;

  modport master (
    output load, digits_in, start, stop, tick,
    input  digits_out, running, zero, done
  );

  modport slave (
    input  load, digits_in, start, stop, tick,
    output digits_out, running, zero, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with run/pause control and a completion pulse.
// With MMSS_MODE=1, digit 1 is tens of seconds (mod 6), giving mm:ss.
module bcd_countdown_timer #(
  parameter int DIGITS    = 4,
  parameter bit MMSS_MODE = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  bcd_countdown_timer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [4*DIGITS-1:0] VAL_ONE = (4*DIGITS)'(1);

  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                done_q, done_d;

  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] sat_val;
  logic                is_zero;
  logic                is_one;

  assign is_zero = (digits_q == '0);
  assign is_one  = (digits_q == VAL_ONE);

  // Per-digit decrement with borrow ripple, and load saturation to each
  // digit's maximum (5 for tens of seconds in mm:ss mode, otherwise 9).
  always_comb begin : digit_math
    logic       borrow;
    logic [3:0] dig;
    logic [3:0] max_dig;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    borrow  = 1'b1;
    dig     = '0;
    max_dig = 4'd9;
    dec_val = '0;
    sat_val = '0;
    for (int k = 0; k < DIGITS; k++) begin
      max_dig = (k == 1 && MMSS_MODE) ? 4'd5 : 4'd9;
      dig     = digits_q[4*k +: 4];
      if (!borrow) begin
        dec_val[4*k +: 4] = dig;
      end else if (dig == 4'd0) begin
        dec_val[4*k +: 4] = max_dig;
      end else begin
        dec_val[4*k +: 4] = dig - 4'd1;
        borrow            = 1'b0;
      end
      dig               = bus.digits_in[4*k +: 4];
      sat_val[4*k +: 4] = (dig > max_dig) ? max_dig : dig;
    end
  end

  // Priority: load > stop > start > tick. A stop in IDLE is ignored but
  // still masks a simultaneous start.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    if (bus.load) begin
      digits_d = sat_val;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.stop && bus.start && !is_zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_PAUSE;
          end else if (bus.tick) begin
            if (is_zero) begin
              state_d = ST_IDLE;
            end else begin
              digits_d = dec_val;
              if (is_one) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!bus.stop && bus.start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      done_q   <= done_d;
    end
  end

  assign bus.digits_out = digits_q;
  assign bus.running    = (state_q == ST_RUN);
  assign bus.zero       = is_zero;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: an mm:ss instance and a decimal instance share
// stimulus; a value-as-integer model plus a hand-written vector table judge both.
module tb_bcd_countdown_timer;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;

  typedef struct {
    bit          load;
    logic [15:0] din;
    bit          start;
    bit          stop;
    bit          tick;
    logic [15:0] exp_mm;
    logic [15:0] exp_dec;
    bit          exp_run;
    bit          exp_done;
  } vec_t;

  logic        clk;
  logic        clear_i;
  logic        load_i;
  logic [15:0] din_i;
  logic        start_i;
  logic        stop_i;
  logic        tick_i;

  int n_checks;
  int n_errors;

  bcd_countdown_timer_if #(.DIGITS(4)) if_mm ();
  bcd_countdown_timer_if #(.DIGITS(4)) if_dec ();

  assign if_mm.load       = load_i;
  assign if_mm.digits_in  = din_i;
  assign if_mm.start      = start_i;
  assign if_mm.stop       = stop_i;
  assign if_mm.tick       = tick_i;
  assign if_dec.load      = load_i;
  assign if_dec.digits_in = din_i;
  assign if_dec.start     = start_i;
  assign if_dec.stop      = stop_i;
  assign if_dec.tick      = tick_i;

  bcd_countdown_timer #(.DIGITS(4), .MMSS_MODE(1'b1)) u_mm (
    .clk   (clk),
    .clear (clear_i),
    .bus   (if_mm.slave)
  );

  bcd_countdown_timer #(.DIGITS(4), .MMSS_MODE(1'b0)) u_dec (
    .clk   (clk),
    .clear (clear_i),
    .bus   (if_dec.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the count is a plain integer (seconds, or a decimal
  // number); digits are derived with mixed-radix division. Index 0 = mm:ss.
  int      m_n    [2];
  mstate_t m_st   [2];
  bit      m_done [2];

  function automatic int radix(input int k, input bit mmss);
    return (k == 1 && mmss) ? 6 : 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int n, input bit mmss);
    logic [15:0] res;
    int w;
    res = '0;
    w   = 1;
    for (int k = 0; k < 4; k++) begin
      res[4*k +: 4] = 4'((n / w) % radix(k, mmss));
      w = w * radix(k, mmss);
    end
    return res;
  endfunction

  function automatic int from_bcd_sat(input logic [15:0] d, input bit mmss);
    int n, w, dig;
    n = 0;
    w = 1;
    for (int k = 0; k < 4; k++) begin
      dig = int'(d[4*k +: 4]);
      if (dig > radix(k, mmss) - 1) dig = radix(k, mmss) - 1;
      n = n + dig * w;
      w = w * radix(k, mmss);
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i]    = 0;
      m_st[i]   = M_IDLE;
      m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (load_i) begin
        m_n[i]  = from_bcd_sat(din_i, i == 0);
        m_st[i] = M_IDLE;
      end else if (m_st[i] == M_IDLE) begin
        if (start_i && !stop_i && m_n[i] != 0) m_st[i] = M_RUN;
      end else if (m_st[i] == M_RUN) begin
        if (stop_i) begin
          m_st[i] = M_PAUSE;
        end else if (tick_i) begin
          if (m_n[i] == 0) begin
            m_st[i] = M_IDLE;
          end else begin
            m_n[i] = m_n[i] - 1;
            if (m_n[i] == 0) begin
              m_st[i]   = M_IDLE;
              m_done[i] = 1'b1;
            end
          end
        end
      end else begin
        if (start_i && !stop_i) m_st[i] = M_RUN;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("mm_model", {13'd0, if_mm.digits_out, if_mm.running, if_mm.zero, if_mm.done},
          {13'd0, to_bcd(m_n[0], 1'b1), m_st[0] == M_RUN, m_n[0] == 0, m_done[0]});
    check("dec_model", {13'd0, if_dec.digits_out, if_dec.running, if_dec.zero, if_dec.done},
          {13'd0, to_bcd(m_n[1], 1'b0), m_st[1] == M_RUN, m_n[1] == 0, m_done[1]});
  endtask

  // Inputs change 1 time unit after the edge, outputs sampled at the same point.
  task automatic cycle(input bit l, input logic [15:0] d, input bit s, input bit p, input bit t);
    load_i  = l;
    din_i   = d;
    start_i = s;
    stop_i  = p;
    tick_i  = t;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  vec_t vecs [22];
  int   done_cnt;
  bit   r_load;
  logic [15:0] r_din;

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0059, 16'h0099, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'h00F9, 1'b0, 1'b0, 1'b0, 16'h0059, 16'h0099, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0042, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0042, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0200, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0200, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h0200, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0200, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0200, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0200, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0159, 16'h0199, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 16'hA7C3, 1'b0, 1'b0, 1'b0, 16'h9753, 16'h9793, 1'b0, 1'b0};

    // Reset state while clear is held, before any clock edge.
    clear_i = 1'b1;
    load_i  = 1'b0;
    din_i   = '0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    tick_i  = 1'b0;
    model_reset();
    #2;
    check("reset_mm", {if_mm.digits_out, if_mm.running, if_mm.zero, if_mm.done}, {16'h0000, 3'b010});
    check("reset_dec", {if_dec.digits_out, if_dec.running, if_dec.zero, if_dec.done}, {16'h0000, 3'b010});
    @(posedge clk);
    #2;
    clear_i = 1'b0;
    @(posedge clk);
    #1;

    // Vector table: corner cases of wrap, saturation, priority and done.
    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].load, vecs[i].din, vecs[i].start, vecs[i].stop, vecs[i].tick);
      check($sformatf("vec%0d_mm", i), {if_mm.digits_out, if_mm.running, if_mm.done},
            {vecs[i].exp_mm, vecs[i].exp_run, vecs[i].exp_done});
      check($sformatf("vec%0d_dec", i), {if_dec.digits_out, if_dec.running, if_dec.done},
            {vecs[i].exp_dec, vecs[i].exp_run, vecs[i].exp_done});
    end

    // 01:30 counted down by 90 spaced ticks; exactly one done pulse.
    done_cnt = 0;
    cycle(1'b1, 16'h0130, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 90; i++) begin
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      if (if_mm.done) done_cnt++;
      if (i == 30) check("mmss_0100", {16'h0, if_mm.digits_out}, 32'h0100);
      if (i == 31) check("mmss_0059", {16'h0, if_mm.digits_out}, 32'h0059);
      if (i == 90) check("mmss_end_done", {if_mm.digits_out, if_mm.done}, {16'h0000, 1'b1});
      if (i < 90) begin
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        if (if_mm.done) done_cnt++;
      end
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    if (if_mm.done) done_cnt++;
    check("mmss_after", {if_mm.running, if_mm.zero, if_mm.done}, 3'b010);
    check("mmss_done_count", done_cnt, 1);

    // Run / pause / resume.
    cycle(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("run_phase", {if_mm.digits_out, if_mm.running}, {16'h0007, 1'b1});
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("pause_phase", {if_mm.digits_out, if_mm.running}, {16'h0007, 1'b0});
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("resume_phase", {if_dec.digits_out, if_mm.digits_out, if_mm.running}, {16'h0005, 16'h0005, 1'b1});

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_load = ($urandom_range(0, 39) == 0);
      r_din  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 32));
      cycle(r_load, r_din, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1);
    end

    // Asynchronous clear between edges, mid-count.
    cycle(1'b1, 16'h0130, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    #2;
    clear_i = 1'b1;
    #1;
    check("async_clear_mm", {if_mm.digits_out, if_mm.running, if_mm.zero, if_mm.done}, {16'h0000, 3'b010});
    check("async_clear_dec", {if_dec.digits_out, if_dec.running, if_dec.zero, if_dec.done}, {16'h0000, 3'b010});
    model_reset();
    tick_i  = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    #2;
    clear_i = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised multi-digit BCD down-counter with run control, used as the cook-time timer in the microwave controller. It replaces per-digit cascaded counters with one block that holds DIGITS BCD digits, optionally in mm:ss form. It decrements once per external tick while running and flags completion. Digit outputs feed the seven-segment display path directly.

Parameters:
DIGITS, 4, number of BCD digits; allowed range 2..8; digit 0 is least significant.
MMSS_MODE, 1, when 1, digit 1 counts mod 6 (tens of seconds), so 4 digits form mm:ss; when 0, every digit counts mod 10.

Ports:
clk  input  1  system clock; all state updates on rising edge.
clear  input  1  asynchronous, active-high reset.
load  input  1  synchronous load strobe, active-high.
digits_in  input  4*DIGITS  BCD value to load; digit k in bits [4k+3:4k].
start  input  1  single-cycle request to begin or resume counting.
stop  input  1  single-cycle request to pause counting.
tick  input  1  single-cycle count-enable pulse, nominally 1 Hz.
digits_out  output  4*DIGITS  current BCD value; same digit packing as digits_in.
running  output  1  high while in the RUNNING state.
zero  output  1  combinational; high when every digit is 0.
done  output  1  single-cycle pulse when the count reaches zero while running.

Behaviour:
- Reset: while clear is high, digits_out=0, state=IDLE, running=0, done=0, zero=1. Reset takes effect immediately, independent of clk, including mid-count.
- States: IDLE, RUNNING, PAUSED. running=1 only in RUNNING.
- Per-cycle priority, highest first: load > stop > start > tick.
- load:
  - Captures digits_in in the next cycle and forces state to IDLE from any state.
  - Any digit >9 saturates to 9. When MMSS_MODE=1, digit 1 >5 saturates to 5.
  - done is not asserted on a load cycle, even when the loaded value is 0.
- IDLE:
  - start with zero=0 goes to RUNNING.
  - start with zero=1 is ignored; state stays IDLE.
  - stop is ignored.
- RUNNING:
  - stop goes to PAUSED; any tick in that same cycle is ignored.
  - tick decrements the whole value by one with borrow. Digit 0 underflows 0 to 9 and borrows from digit 1. Digit 1 underflows 0 to 5 when MMSS_MODE=1, otherwise 0 to 9. Higher digits underflow 0 to 9.
  - When a tick takes the value from 1 (all higher digits 0, digit 0 = 1) to 0: the next state is IDLE, and done pulses high for exactly the cycle after that edge.
  - The value never wraps below 0. A tick seen in RUNNING with zero=1 only forces IDLE; done is not pulsed.
  - start in RUNNING has no effect.
- PAUSED:
  - The value is held and ticks are ignored.
  - start goes to RUNNING.
  - stop has no effect.
- Latency:
  - The value changes on the clk edge that samples tick=1; digits_out is registered.
  - running updates on the clk edge that samples start or stop.
- Simultaneous events:
  - start+stop in the same cycle: stop wins.
  - load+tick: load wins; the loaded value is not decremented that cycle.
- tick wider than one cycle decrements once per cycle it is high; the driver must supply single-cycle pulses.

Test Plan:
1. Reset, then load 0x0130 (DIGITS=4, MMSS=1), start, apply 90 ticks -> value steps 01:30, 01:29 … 01:00, 00:59 … 00:00. done pulses exactly once on the cycle after the 90th tick. running then =0 and zero =1.
2. Load 0x0100, start, one tick -> value 00:59; digit 1 wraps to 5, not 9. Repeat with MMSS_MODE=0 and load 0x0100, one tick -> value 0099.
3. Load 0x0010, start, 3 ticks, stop, 5 ticks, start, 2 ticks -> value goes 0010, 0009, 0008, 0007, holds 0007 for the 5 paused ticks, then 0006, 0005. running is 1, 0, 1 across the phases.
4. Load 0x0000, then start -> state stays IDLE, running=0, done never asserts. Then load 0x00F9 -> value saturates to 0x0059.
5. Load and tick in the same cycle while RUNNING at 0x0042 with digits_in=0x0200 -> value 0x0200 and state IDLE. Separately, start+stop in the same cycle from PAUSED -> state stays PAUSED.
6. Assert clear asynchronously between clk edges mid-count -> digits_out=0, running=0, zero=1, with no done pulse afterwards.
